mealy_machine: RTL and testbench

- Synchronous 3-state Mealy FSM that detects the serial bit pattern "101" on a 1-bit input stream, with overlapping matches allowed.
- Output is combinational from current state and current input, so it can change mid-cycle when `in` changes.
- Used as a small control/pattern-detect leaf block; no handshake, one bit consumed per rising clock edge.

---
 rtl/mealy_machine.sv | 66 ++++++
 tb/tb_mealy_machine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_machine.sv
// Three-state Mealy detector for the serial pattern "101", overlapping matches allowed.
// The detect flag is combinational from the current state and the live input bit.
module mealy_machine (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  typedef enum logic [1:0] {
    S0 = 2'b00,  // idle, no prefix
    S1 = 2'b01,  // "1" seen
    S2 = 2'b10   // "10" seen
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // State register with synchronous reset to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S0;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and detect logic; encoding 2'b11 falls to idle with no detect
  always_comb begin
    next_state_s = S0;
    out          = 1'b0;
    case (state_r)
      S0: begin
        if (in) begin
          next_state_s = S1;
        end else begin
          next_state_s = S0;
        end
      end
      S1: begin
        if (in) begin
          next_state_s = S1;
        end else begin
          next_state_s = S2;
        end
      end
      S2: begin
        if (in) begin
          next_state_s = S1;
        end else begin
          next_state_s = S0;
        end
        if (rst) begin
          out = 1'b0;
        end else begin
          out = in;
        end
      end
      default: begin
        next_state_s = S0;
        out          = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mealy_machine.sv
// Self-checking bench for mealy_machine: a reference model based on the bit history
// since the last reset predicts the detect flag for directed and random streams.
module tb_mealy_machine;

  logic clk;
  logic rst;
  logic in;
  logic out;

  int checks;
  int errors;

  // Bits consumed by the detector since the last reset edge, oldest first
  bit hist[$];

  mealy_machine dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detect is high when not in reset, the last two consumed bits were 1 then 0, and in is 1
  function automatic logic model_out();
    if (rst) return 1'b0;
    if (hist.size() < 2) return 1'b0;
    if (hist[hist.size()-2] == 1'b1 && hist[hist.size()-1] == 1'b0 && in == 1'b1) return 1'b1;
    return 1'b0;
  endfunction

  // Drive inputs shortly after an edge, then let combinational logic settle
  task automatic drive(input logic b, input logic r);
    rst = r;
    in  = b;
    #2;
  endtask

  // Clock one edge and update the history model with what was sampled there
  task automatic tick();
    @(posedge clk);
    if (rst) hist.delete();
    else hist.push_back(in);
    #1;
  endtask

  task automatic test_reset();
    logic exp;
    drive(1'b1, 1'b1);
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL reset_forces_out: out=%b expected=0", out);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      exp = model_out();
      checks++;
      if (out !== exp) begin
        errors++;
        $display("FAIL reset_idle[%0d]: out=%b expected=%b", i, out, exp);
      end
      tick();
    end
    // still idle: a lone 1 must not detect
    drive(1'b1, 1'b0);
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_probe: out=%b expected=0", out);
    end
    tick();
  endtask

  task automatic test_basic_detect();
    logic pat[3];
    logic exp;
    pat = '{1'b1, 1'b0, 1'b1};
    drive(1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(pat[i], 1'b0);
      exp = model_out();
      checks++;
      if (out !== exp || (i == 2 && out !== 1'b1)) begin
        errors++;
        $display("FAIL basic_detect[%0d]: out=%b expected=%b", i, out, exp);
      end
      tick();
    end
    drive(1'b0, 1'b0);
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: out=%b expected=0", out);
    end
    tick();
  endtask

  task automatic test_overlap();
    logic pat_a[5];
    logic pat_b[4];
    logic exp_a[5];
    logic exp_b[4];
    pat_a = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_a = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pat_b = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_b = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(pat_a[i], 1'b0);
      checks++;
      if (out !== exp_a[i] || out !== model_out()) begin
        errors++;
        $display("FAIL overlap_10101[%0d]: out=%b expected=%b", i, out, exp_a[i]);
      end
      tick();
    end
    drive(1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(pat_b[i], 1'b0);
      checks++;
      if (out !== exp_b[i] || out !== model_out()) begin
        errors++;
        $display("FAIL overlap_1101[%0d]: out=%b expected=%b", i, out, exp_b[i]);
      end
      tick();
    end
  endtask

  task automatic test_mid_cycle();
    drive(1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0);
    checks++;
    if (out !== 1'b1) begin
      errors++;
      $display("FAIL mid_cycle_high: out=%b expected=1", out);
    end
    in = 1'b0;
    #2;
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL mid_cycle_low: out=%b expected=0", out);
    end
    tick();
    // back in idle: 1 then 0 then 1 is needed again, so a 1 now must not detect
    drive(1'b1, 1'b0);
    checks++;
    if (out !== 1'b0 || model_out() !== 1'b0) begin
      errors++;
      $display("FAIL mid_cycle_next_idle: out=%b expected=0", out);
    end
    tick();
  endtask

  task automatic test_break();
    logic pat_a[4];
    logic pat_b[3];
    logic exp;
    pat_a = '{1'b1, 1'b0, 1'b0, 1'b1};
    pat_b = '{1'b1, 1'b1, 1'b1};
    drive(1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(pat_a[i], 1'b0);
      exp = model_out();
      checks++;
      if (out !== exp || out !== 1'b0) begin
        errors++;
        $display("FAIL break_1001[%0d]: out=%b expected=0", i, out);
      end
      tick();
    end
    drive(1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(pat_b[i], 1'b0);
      checks++;
      if (out !== 1'b0) begin
        errors++;
        $display("FAIL break_111[%0d]: out=%b expected=0", i, out);
      end
      tick();
    end
    // still holding a "1" prefix: 0 then 1 completes a match
    drive(1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0);
    checks++;
    if (out !== 1'b1) begin
      errors++;
      $display("FAIL break_111_then_01: out=%b expected=1", out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic pat[3];
    drive(1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1);
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_out: out=%b expected=0", out);
    end
    tick();
    // landed in idle, not "1 seen": 0 then 1 must not detect
    drive(1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0);
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_to_idle: out=%b expected=0", out);
    end
    tick();
    drive(1'b0, 1'b1);
    tick();
    pat = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(pat[i], 1'b0);
      checks++;
      if (out !== (i == 2 ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL reset_mid_redetect[%0d]: out=%b expected=%b", i, out, (i == 2));
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic exp;
    logic b;
    logic r;
    for (int i = 0; i < 400; i++) begin
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
      drive(b, r);
      exp = model_out();
      checks++;
      if (out !== exp) begin
        errors++;
        $display("FAIL random[%0d]: out=%b expected=%b in=%b rst=%b", i, out, exp, b, r);
      end
      if ($urandom_range(0, 3) == 0) begin
        in = ~in;
        #2;
        exp = model_out();
        checks++;
        if (out !== exp) begin
          errors++;
          $display("FAIL random_glitch[%0d]: out=%b expected=%b in=%b rst=%b", i, out, exp, in, rst);
        end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    in     = 1'b0;
    #1;
    test_reset();
    test_basic_detect();
    test_overlap();
    test_mid_cycle();
    test_break();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
